// File: rtl/pipe_riscv_pkg.sv
// Shared definitions for the pipelined core: opcode/type encodings and the
// fetch-queue entry layout.
package pipe_riscv_pkg;

  localparam int unsigned FQ_AW = 16;
  localparam int unsigned FQ_DW = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQZ = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    RR_ALU,
    RI_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT
  } instr_type_e;

  typedef struct packed {
    logic [FQ_DW-1:0] ir;
    logic [FQ_AW-1:0] npc;
  } fq_entry_t;

endpackage

// File: rtl/fq_sync_fifo.sv
// Synchronous FIFO with a synchronous clear that wins over push/pop.
// Head is a direct read of the oldest slot; occupancy is exported as count.
module fq_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; clear empties the queue outright.
  always_comb begin
    do_push  = push && !clear;
    do_pop   = pop && !empty && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pipe_fetch_queue.sv
// Instruction prefetch queue: issues in-order word fetches with credit-based
// flow control, buffers responses with their NPC, and squashes stale
// in-flight responses after a taken-branch redirect.
module pipe_fetch_queue
  import pipe_riscv_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [DW-1:0] if_ir,
  output logic [AW-1:0] if_npc
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          accept;
  logic [CW:0]   outstanding;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fq_entry_t     push_entry, head_entry;

  fq_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fq_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (redirect_valid),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_entry)
  );

  assign imem_addr = pc_q;
  assign if_valid  = !fifo_empty;
  assign if_ir     = if_valid ? head_entry.ir  : '0;
  assign if_npc    = if_valid ? head_entry.npc : '0;
  assign fifo_pop  = if_valid && if_ready && !redirect_valid;

  // Issue credit, response accounting and redirect handling.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    fifo_push  = 1'b0;
    push_entry = '{ir: imem_rsp_data, npc: rsp_pc_q + AW'(1)};

    outstanding    = {1'b0, fifo_count} + {1'b0, inflight_q};
    imem_req_valid = !rst && !halt && !redirect_valid && (outstanding < LIMIT);
    accept         = imem_req_valid && imem_req_ready;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      rsp_pc_d   = redirect_pc;
      inflight_d = inflight_q - CW'(imem_rsp_valid);
      // inflight already includes earlier stale requests, so the surviving
      // in-flight count alone is the new drop count (no double counting on
      // back-to-back redirects).
      drop_d     = inflight_d;
    end else begin
      if (accept) pc_d = pc_q + AW'(1);
      inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + AW'(1);
        end
      end
    end
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Randomised and scenario bench for pipe_fetch_queue with an in-bench
// variable-latency memory and a queue-based reference model.
module tb_pipe_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, halt, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, if_valid, if_ready;
  logic [15:0] redirect_pc, imem_addr, imem_rsp_data, if_ir, if_npc;

  always #5 clk = ~clk;

  pipe_fetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (16),
    .DW       (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ir          (if_ir),
    .if_npc         (if_npc)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        outq[$];
  logic [31:0] fq[$];
  logic [15:0] m_pc;
  bit          m_known;
  int          cyc, last_due, lat;
  int          n_vec, n_err;

  bit          obs_req, obs_valid;
  logic [15:0] obs_addr, obs_ir, obs_npc;
  bit          cap_armed;
  logic [15:0] cap_ir, cap_npc;
  int          cap_cyc;
  logic [15:0] acc_list[$];
  int          acc_cyc[$];
  int          n_req, n_val;

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h03F1;
    return (p + 16'h1234) ^ (a >> 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit rsp_now();
    return outq.size() > 0 && outq[0].due <= cyc;
  endfunction

  task automatic step(input bit s_rst, input bit s_halt, input bit s_redir,
                      input logic [15:0] s_rpc, input bit s_rrdy, input bit s_ifrdy);
    bit          rsp, e_req, e_val;
    logic [31:0] hd;
    req_t        r;
    @(negedge clk);
    rsp = rsp_now();
    rst = s_rst; halt = s_halt; redirect_valid = s_redir; redirect_pc = s_rpc;
    imem_req_ready = s_rrdy; if_ready = s_ifrdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(outq[0].addr) : 16'($urandom);
    #1;
    e_req = !s_rst && !s_halt && !s_redir && (fq.size() + outq.size() < DEPTH);
    e_val = fq.size() != 0;
    hd    = e_val ? fq[0] : 32'h0;

    obs_req = imem_req_valid; obs_addr = imem_addr;
    obs_valid = if_valid; obs_ir = if_ir; obs_npc = if_npc;
    if (obs_req) n_req++;
    if (obs_valid) n_val++;
    if (obs_req && s_rrdy) begin acc_list.push_back(obs_addr); acc_cyc.push_back(cyc); end
    if (cap_armed && obs_valid) begin
      cap_armed = 0; cap_ir = obs_ir; cap_npc = obs_npc; cap_cyc = cyc;
    end

    if (m_known) begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
      if (e_req) chk("imem_addr", {16'b0, imem_addr}, {16'b0, m_pc});
      chk("if_valid", {31'b0, if_valid}, {31'b0, e_val});
      chk("if_ir", {16'b0, if_ir}, {16'b0, hd[31:16]});
      chk("if_npc", {16'b0, if_npc}, {16'b0, hd[15:0]});
    end

    if (s_rst) begin
      outq.delete(); fq.delete();
      m_pc = 16'h0000; m_known = 1; last_due = cyc;
    end else if (s_redir) begin
      if (rsp) void'(outq.pop_front());
      foreach (outq[i]) outq[i].stale = 1;
      fq.delete();
      m_pc = s_rpc;
    end else begin
      if (e_val && s_ifrdy) void'(fq.pop_front());
      if (rsp) begin
        r = outq.pop_front();
        if (!r.stale) fq.push_back({memf(r.addr), r.addr + 16'd1});
      end
      if (e_req && s_rrdy) begin
        r.addr  = m_pc;
        r.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.stale = 0;
        last_due = r.due;
        outq.push_back(r);
        m_pc = m_pc + 16'd1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit s_rrdy, input bit s_ifrdy, input bit s_halt);
    for (int i = 0; i < n; i++) step(0, s_halt, 0, 16'h0, s_rrdy, s_ifrdy);
  endtask

  task automatic arm();
    cap_armed = 1; cap_ir = 16'hDEAD; cap_npc = 16'hDEAD; cap_cyc = -100;
    acc_list.delete(); acc_cyc.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_vec = 0; n_err = 0; cyc = 0; last_due = 0; m_known = 0; cap_armed = 0;
    rst = 1; halt = 0; redirect_valid = 0; redirect_pc = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; if_ready = 0;

    // 1-cycle memory, streaming delivery.
    lat = 1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    arm();
    run(10, 1, 1, 0);
    chk("A_first_npc", {16'b0, cap_npc}, 32'h0001);
    chk("A_first_ir", {16'b0, cap_ir}, {16'b0, memf(16'h0000)});
    chk("A_latency", cap_cyc - (acc_cyc.size() > 0 ? acc_cyc[0] : -100), 2);
    chk("A_addr1", {16'b0, acc_list.size() > 1 ? acc_list[1] : 16'hDEAD}, 32'h0001);

    // Decode stalled, 3-cycle memory: credit limit stops at 4.
    lat = 3;
    step(1, 0, 0, 0, 0, 0);
    arm();
    run(12, 1, 0, 0);
    chk("B_accepts", acc_list.size(), 4);
    chk("B_req_low", {31'b0, obs_req}, 0);
    chk("B_valid", {31'b0, obs_valid}, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("B_no_req_pop_cycle", {31'b0, obs_req}, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("B_req_after_pop", {31'b0, obs_req}, 1);
    chk("B_addr_after_pop", {16'b0, obs_addr}, 32'h0004);
    run(12, 1, 1, 0);

    // Redirect with 4,5,6 in flight.
    lat = 5;
    step(1, 0, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_pc == 16'h0004 && outq.size() == 0 && fq.size() == 0) found = 1;
      else step(0, 0, 0, 0, m_pc < 16'h0004, 1);
    end
    chk("C_reach_pc4", {31'b0, found}, 1);
    arm();
    run(3, 1, 1, 0);
    chk("C_acc_4", {16'b0, acc_list.size() > 0 ? acc_list[0] : 16'hDEAD}, 32'h0004);
    chk("C_acc_6", {16'b0, acc_list.size() > 2 ? acc_list[2] : 16'hDEAD}, 32'h0006);
    step(0, 0, 1, 16'h0020, 1, 1);
    arm();
    run(16, 1, 1, 0);
    chk("C_npc", {16'b0, cap_npc}, 32'h0021);
    chk("C_ir", {16'b0, cap_ir}, {16'b0, memf(16'h0020)});

    // Redirect in the same cycle as a response beat.
    lat = 2;
    step(1, 0, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (rsp_now()) found = 1;
      else step(0, 0, 0, 0, 1, 1);
    end
    chk("D_rsp_seen", {31'b0, found}, 1);
    step(0, 0, 1, 16'h0040, 1, 1);
    arm();
    run(12, 1, 1, 0);
    chk("D_npc", {16'b0, cap_npc}, 32'h0041);

    // Halt with two in flight.
    lat = 3;
    step(1, 0, 0, 0, 0, 0);
    run(2, 1, 1, 0);
    n_req = 0; n_val = 0;
    run(8, 1, 1, 1);
    chk("E_halt_no_req", n_req, 0);
    chk("E_halt_delivered", n_val, 2);
    arm();
    run(4, 1, 1, 0);
    chk("E_resume_addr", {16'b0, acc_list.size() > 0 ? acc_list[0] : 16'hDEAD}, 32'h0002);

    // PC wrap at 16'hFFFF, then reset mid-stream.
    lat = 1;
    step(0, 0, 1, 16'hFFFF, 1, 1);
    arm();
    run(8, 1, 1, 0);
    chk("F_wrap_npc", {16'b0, cap_npc}, 32'h0000);
    chk("F_wrap_ir", {16'b0, cap_ir}, {16'b0, memf(16'hFFFF)});
    chk("F_acc0", {16'b0, acc_list.size() > 0 ? acc_list[0] : 16'hDEAD}, 32'hFFFF);
    chk("F_acc1", {16'b0, acc_list.size() > 1 ? acc_list[1] : 16'hDEAD}, 32'h0000);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("F_rst_valid", {31'b0, obs_valid}, 0);
    chk("F_rst_req", {31'b0, obs_req}, 1);
    chk("F_rst_addr", {16'b0, obs_addr}, 32'h0000);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 5);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 29) == 0, 16'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
